// File: rtl/clkgen_pkg.sv
// Shared types and constants for the clock-enable / reset sequencer.
// Holds the sequencer FSM state encoding and the lock-loss counter width.
package clkgen_pkg;

   localparam int unsigned LOCK_CNT_W = 8;

   typedef enum logic [1:0] {
      StWaitLock = 2'd0,
      StStretch  = 2'd1,
      StSeq      = 2'd2,
      StRun      = 2'd3
   } clkgen_state_e;

endpackage

// File: rtl/clkgen_div_ch.sv
// One channel's clock-enable divider: divide-ratio capture, counter and registered pulse.
// The ratio tracks div_i while the channel is held in reset and freezes once it is released.
module clkgen_div_ch #(
   parameter int unsigned DIV_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             run_i,
   input  logic             run_next_i,
   input  logic [DIV_W-1:0] div_i,
   output logic             clk_en_o
);

   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             en_q, en_d;

   always_comb begin
      div_d = run_i ? div_q : div_i;
      cnt_d = '0;
      en_d  = 1'b0;
      // run_next_i gates the pulse so the enable drops on the same edge as the reset
      if (run_i && run_next_i) begin
         if (cnt_q == div_q) begin
            en_d = 1'b1;
         end else begin
            cnt_d = cnt_q + DIV_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         div_q <= '0;
         cnt_q <= '0;
         en_q  <= 1'b0;
      end else begin
         div_q <= div_d;
         cnt_q <= cnt_d;
         en_q  <= en_d;
      end
   end

   assign clk_en_o = en_q;

endmodule

// File: rtl/clkgen_rst_seq.sv
// PLL-lock qualified reset sequencer with staggered per-channel release and clock enables.
// Optional lock-loss monitor outputs are built only when CLKGEN_LOCK_MON_EN is defined.
module clkgen_rst_seq
   import clkgen_pkg::*;
#(
   parameter int unsigned N_CH        = 2,
   parameter int unsigned DIV_W       = 8,
   parameter int unsigned STRETCH_CYC = 16,
   parameter int unsigned SEQ_GAP     = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  IO_CLK,
   input  logic                  IO_RST_N,
   input  logic                  pll_locked_i,
   input  logic [N_CH*DIV_W-1:0] div_i,
   output logic                  rst_sys_n,
   output logic [N_CH-1:0]       rst_ch_n_o,
   output logic [N_CH-1:0]       clk_en_o,
   output logic                  lock_lost_o,
   output logic [LOCK_CNT_W-1:0] lock_loss_cnt_o
);

   localparam int unsigned StrW = (STRETCH_CYC > 1) ? $clog2(STRETCH_CYC) : 1;
   localparam int unsigned GapW = (SEQ_GAP > 1) ? $clog2(SEQ_GAP) : 1;
   localparam int unsigned ChW  = (N_CH > 1) ? $clog2(N_CH) : 1;

   localparam logic [StrW-1:0] StrLast = StrW'(STRETCH_CYC - 1);
   localparam logic [GapW-1:0] GapLast = GapW'(SEQ_GAP - 1);
   localparam logic [ChW-1:0]  ChLast  = ChW'(N_CH - 1);

   clkgen_state_e    state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic             lock_s;
   logic [StrW-1:0]  str_q, str_d;
   logic [GapW-1:0]  gap_q, gap_d;
   logic [ChW-1:0]   idx_q, idx_d;
   logic             rst_sys_q, rst_sys_d;
   logic [N_CH-1:0]  rst_ch_q, rst_ch_d;

   always_ff @(posedge IO_CLK or negedge IO_RST_N) begin
      if (!IO_RST_N) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked_i};
      end
   end

   assign lock_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d   = state_q;
      str_d     = str_q;
      gap_d     = gap_q;
      idx_d     = idx_q;
      rst_sys_d = rst_sys_q;
      rst_ch_d  = rst_ch_q;

      unique case (state_q)
         StWaitLock: begin
            rst_sys_d = 1'b0;
            rst_ch_d  = '0;
            str_d     = '0;
            if (lock_s) begin
               state_d = StStretch;
            end
         end

         StStretch: begin
            if (!lock_s) begin
               state_d = StWaitLock;
               str_d   = '0;
            end else if (str_q == StrLast) begin
               state_d   = StSeq;
               rst_sys_d = 1'b1;
               gap_d     = '0;
               idx_d     = '0;
            end else begin
               str_d = str_q + StrW'(1);
            end
         end

         StSeq: begin
            // Lock loss takes priority over a release due on the same cycle
            if (!lock_s) begin
               state_d   = StWaitLock;
               rst_sys_d = 1'b0;
               rst_ch_d  = '0;
            end else if (gap_q == GapLast) begin
               gap_d = '0;
               for (int unsigned k = 0; k < N_CH; k++) begin
                  if (idx_q == ChW'(k)) begin
                     rst_ch_d[k] = 1'b1;
                  end
               end
               if (idx_q == ChLast) begin
                  state_d = StRun;
               end else begin
                  idx_d = idx_q + ChW'(1);
               end
            end else begin
               gap_d = gap_q + GapW'(1);
            end
         end

         StRun: begin
            if (!lock_s) begin
               state_d   = StWaitLock;
               rst_sys_d = 1'b0;
               rst_ch_d  = '0;
            end
         end

         default: begin
            state_d   = StWaitLock;
            rst_sys_d = 1'b0;
            rst_ch_d  = '0;
         end
      endcase
   end

   always_ff @(posedge IO_CLK or negedge IO_RST_N) begin
      if (!IO_RST_N) begin
         state_q   <= StWaitLock;
         str_q     <= '0;
         gap_q     <= '0;
         idx_q     <= '0;
         rst_sys_q <= 1'b0;
         rst_ch_q  <= '0;
      end else begin
         state_q   <= state_d;
         str_q     <= str_d;
         gap_q     <= gap_d;
         idx_q     <= idx_d;
         rst_sys_q <= rst_sys_d;
         rst_ch_q  <= rst_ch_d;
      end
   end

   assign rst_sys_n  = rst_sys_q;
   assign rst_ch_n_o = rst_ch_q;

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      clkgen_div_ch #(
         .DIV_W(DIV_W)
      ) u_div (
         .clk_i     (IO_CLK),
         .rst_ni    (IO_RST_N),
         .run_i     (rst_ch_q[k]),
         .run_next_i(rst_ch_d[k]),
         .div_i     (div_i[k*DIV_W +: DIV_W]),
         .clk_en_o  (clk_en_o[k])
      );
   end

`ifdef CLKGEN_LOCK_MON_EN
   logic                  loss_evt;
   logic                  lost_q;
   logic [LOCK_CNT_W-1:0] loss_cnt_q;

   assign loss_evt = !lock_s && ((state_q == StSeq) || (state_q == StRun));

   always_ff @(posedge IO_CLK or negedge IO_RST_N) begin
      if (!IO_RST_N) begin
         lost_q     <= 1'b0;
         loss_cnt_q <= '0;
      end else if (loss_evt) begin
         lost_q <= 1'b1;
         if (loss_cnt_q != '1) begin
            loss_cnt_q <= loss_cnt_q + LOCK_CNT_W'(1);
         end
      end
   end

   assign lock_lost_o     = lost_q;
   assign lock_loss_cnt_o = loss_cnt_q;
`else
   assign lock_lost_o     = 1'b0;
   assign lock_loss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_clkgen_rst_seq.sv
// Directed bench for clkgen_rst_seq: cold start, stagger, dividers, lock loss, glitch, saturation.
// Status expectations follow CLKGEN_LOCK_MON_EN when the bench is built with that macro.
module tb_clkgen_rst_seq;

`ifdef CLKGEN_LOCK_MON_EN
   localparam bit MON = 1'b1;
`else
   localparam bit MON = 1'b0;
`endif

   logic        IO_CLK;
   logic        IO_RST_N;
   logic        pll_locked_i;
   logic [15:0] div_i;
   logic        rst_sys_n;
   logic [1:0]  rst_ch_n_o;
   logic [1:0]  clk_en_o;
   logic        lock_lost_o;
   logic [7:0]  lock_loss_cnt_o;

   int errors = 0;
   int checks = 0;

   clkgen_rst_seq #(
      .N_CH       (2),
      .DIV_W      (8),
      .STRETCH_CYC(16),
      .SEQ_GAP    (4),
      .SYNC_STAGES(2)
   ) dut (
      .IO_CLK         (IO_CLK),
      .IO_RST_N       (IO_RST_N),
      .pll_locked_i   (pll_locked_i),
      .div_i          (div_i),
      .rst_sys_n      (rst_sys_n),
      .rst_ch_n_o     (rst_ch_n_o),
      .clk_en_o       (clk_en_o),
      .lock_lost_o    (lock_lost_o),
      .lock_loss_cnt_o(lock_loss_cnt_o)
   );

   initial IO_CLK = 1'b0;
   always #5 IO_CLK = ~IO_CLK;

   task automatic step();
      @(posedge IO_CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // 40 edges from the point the synchroniser first sees lock: release at 19/23/27
   task automatic run_seq(input int d0, input bit change_div);
      int first0;
      logic [1:0] exp_ch, exp_en;
      first0 = 23 + d0 + 1;
      for (int n = 1; n <= 40; n++) begin
         step();
         exp_ch    = {n >= 27, n >= 23};
         exp_en[0] = (n >= first0) && (((n - first0) % (d0 + 1)) == 0);
         exp_en[1] = (n >= 28);
         chk($sformatf("rst_sys_n@%0d", n), rst_sys_n, n >= 19);
         chk($sformatf("rst_ch_n@%0d", n), rst_ch_n_o, exp_ch);
         chk($sformatf("clk_en@%0d", n), clk_en_o, exp_en);
         if (change_div && n == 30) div_i[7:0] = 8'd7;
      end
   endtask

   task automatic lose_lock_run(input int exp_cnt);
      pll_locked_i = 1'b0;
      step();
      chk("loss_sys_hold1", rst_sys_n, 1'b1);
      step();
      chk("loss_sys_hold2", rst_sys_n, 1'b1);
      chk("loss_ch_hold2", rst_ch_n_o, 2'b11);
      step();
      chk("loss_sys", rst_sys_n, 1'b0);
      chk("loss_ch", rst_ch_n_o, 2'b00);
      chk("loss_en", clk_en_o, 2'b00);
      chk("loss_flag", lock_lost_o, MON);
      chk("loss_cnt", lock_loss_cnt_o, MON ? exp_cnt : 0);
   endtask

   initial begin
      IO_RST_N     = 1'b0;
      pll_locked_i = 1'b1;
      div_i        = 16'h0003;
      repeat (3) step();
      chk("rst_sys_n", rst_sys_n, 1'b0);
      chk("rst_ch_n", rst_ch_n_o, 2'b00);
      chk("rst_clk_en", clk_en_o, 2'b00);
      chk("rst_lost", lock_lost_o, 1'b0);
      chk("rst_cnt", lock_loss_cnt_o, 8'd0);

      // Cold start, div0=3 / div1=0; div0 raised to 7 mid-run must not take effect
      IO_RST_N = 1'b1;
      run_seq(3, 1'b1);
      lose_lock_run(1);

      // Relock: full sequence repeats and the new ratio 7 is now in use
      pll_locked_i = 1'b1;
      run_seq(7, 1'b0);
      lose_lock_run(2);

      // 3-cycle lock glitch at stretch count 10 restarts the stretch from 0
      pll_locked_i = 1'b1;
      for (int n = 1; n <= 40; n++) begin
         step();
         chk($sformatf("glitch_sys@%0d", n), rst_sys_n, n >= 35);
         chk($sformatf("glitch_ch@%0d", n), rst_ch_n_o, {1'b0, n >= 39});
         if (n == 13) pll_locked_i = 1'b0;
         if (n == 16) pll_locked_i = 1'b1;
      end
      chk("glitch_cnt", lock_loss_cnt_o, MON ? 2 : 0);

      // Loss during SEQ, then 300 more SEQ-phase losses to saturate the counter
      pll_locked_i = 1'b0;
      repeat (3) step();
      chk("seq_loss_ch", rst_ch_n_o, 2'b00);
      chk("seq_loss_cnt", lock_loss_cnt_o, MON ? 3 : 0);
      for (int i = 0; i < 300; i++) begin
         pll_locked_i = 1'b1;
         repeat (19) step();
         chk("sat_sys_up", rst_sys_n, 1'b1);
         pll_locked_i = 1'b0;
         repeat (3) step();
         chk("sat_sys_down", rst_sys_n, 1'b0);
         if (i == 251) chk("sat_cnt_255", lock_loss_cnt_o, MON ? 255 : 0);
      end
      chk("sat_cnt", lock_loss_cnt_o, MON ? 255 : 0);
      chk("sat_flag", lock_lost_o, MON);

      // Asynchronous reset mid-cycle while running clears everything at once
      pll_locked_i = 1'b1;
      repeat (30) step();
      chk("pre_arst_ch", rst_ch_n_o, 2'b11);
      #2;
      IO_RST_N = 1'b0;
      #1;
      chk("arst_sys", rst_sys_n, 1'b0);
      chk("arst_ch", rst_ch_n_o, 2'b00);
      chk("arst_en", clk_en_o, 2'b00);
      chk("arst_flag", lock_lost_o, 1'b0);
      chk("arst_cnt", lock_loss_cnt_o, 8'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
